hamming_encode_arbiter: RTL and testbench

Shares one `hamming_encoder` instance (64-bit data in, 71-bit Hamming codeword out, bits numbered [71:1]) between `NUM_REQ` requesters. Each requester presents a data word with a valid/ready handshake. A round-robin arbiter picks one requester per cycle. The chosen word is encoded and the codeword is registered, together with the winner's ID, into a single-entry output stage with its own valid/ready handshake. The block sits between the memory-write clients and the ECC storage path.

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_encoder.sv | 29 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/hamming_encode_arbiter.sv | 78 +++++++
 tb/tb_hamming_encode_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(71,64) definitions: widths, parity positions, codeword type
// and constant helpers that map data bits and parity coverage onto positions.
package hamming_pkg;

    localparam int DATA_W  = 64;
    localparam int CODE_W  = 71;
    localparam int NPARITY = 7;

    localparam int PARITY_POS [NPARITY] = '{1, 2, 4, 8, 16, 32, 64};

    typedef logic [CODE_W:1] codeword_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_e;

    // Codeword position of data bit idx (1-based); data fills non-power-of-two slots in order.
    function automatic int data_pos(input int idx);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int q = 1; q <= CODE_W; q++) begin
            if ((q & (q - 1)) != 0) begin
                cnt++;
                if (cnt == idx) pos = q;
            end
        end
        return pos;
    endfunction

    function automatic codeword_t parity_mask(input int j);
        codeword_t m;
        m = '0;
        for (int q = 1; q <= CODE_W; q++) m[q] = q[j];
        return m;
    endfunction

endpackage

// File: rtl/hamming_encoder.sv
// Combinational Hamming(71,64) encoder, even parity, parity bits at powers of two.
module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [DATA_W:1] din,
    output codeword_t       codeword
);

    codeword_t          w_placed;
    logic [NPARITY-1:0] w_par;

    always_comb begin
        w_placed = '0;
        for (int i = 1; i <= DATA_W; i++) w_placed[data_pos(i)] = din[i];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPARITY; gi++) begin : g_par
            assign w_par[gi] = ^(w_placed & parity_mask(gi));
        end
    endgenerate

    always_comb begin
        codeword = w_placed;
        for (int j = 0; j < NPARITY; j++) codeword[PARITY_POS[j]] = w_par[j];
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int w_idx;

    // Scan from the farthest offset back to ptr so the nearest requester wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/hamming_encode_arbiter.sv
// Round-robin sharing of one Hamming encoder among NUM_REQ writers, feeding a
// single-entry registered output stage that sustains one word per cycle.
module hamming_encode_arbiter
    import hamming_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output codeword_t                 out_codeword,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy
);

    stage_e           r_state;
    logic [ID_W-1:0]  r_ptr;
    codeword_t        r_codeword;
    logic [ID_W-1:0]  r_id;

    logic             w_can_accept;
    logic             w_xfer;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic [ID_W-1:0]  w_ptr_next;
    logic [DATA_W-1:0] w_data;
    codeword_t        w_codeword;

    assign w_can_accept = (r_state == ST_EMPTY) | out_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // Grants only exist for valid requesters, so any ready bit is a transfer.
    assign req_ready  = (w_can_accept && !rst) ? w_grant : '0;
    assign w_xfer     = |req_ready;
    assign w_data     = req_data[DATA_W*w_grant_idx +: DATA_W];
    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    hamming_encoder u_enc (
        .din      (w_data),
        .codeword (w_codeword)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_ptr      <= '0;
            r_codeword <= '0;
            r_id       <= '0;
        end else if (w_xfer) begin
            r_state    <= ST_FULL;
            r_codeword <= w_codeword;
            r_id       <= w_grant_idx;
            r_ptr      <= w_ptr_next;
        end else if (out_ready) begin
            r_state    <= ST_EMPTY;
        end
    end

    assign out_valid    = (r_state == ST_FULL);
    assign out_codeword = r_codeword;
    assign out_id       = r_id;
    assign busy         = out_valid | (|req_valid);

endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Scoreboard bench: a behavioural arbiter/encoder model queues expected words,
// a separate monitor pops and compares each codeword the DUT hands downstream.
module tb_hamming_encode_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*64-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [71:1]       out_codeword;
    logic [1:0]        out_id;
    logic              busy;

    always #5 clk = ~clk;

    hamming_encode_arbiter #(.NUM_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_codeword (out_codeword),
        .out_id       (out_id),
        .busy         (busy)
    );

    typedef struct {
        int          id;
        logic [71:1] cw;
    } exp_t;

    exp_t exp_q[$];
    int   dut_log[$];
    int   total = 0;
    int   bad   = 0;
    int   m_ptr = 0;
    bit   m_full = 0;
    bit   granted[N];
    bit   keep_valid[N];
    bit   rand_mode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Parity vector equals the XOR of the positions of all set data bits.
    function automatic logic [71:1] ref_encode(input logic [63:0] d);
        logic [71:1] cw;
        int k;
        int syn;
        cw  = '0;
        k   = 0;
        syn = 0;
        for (int pos = 1; pos <= 71; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                if (d[k]) begin
                    cw[pos] = 1'b1;
                    syn     = syn ^ pos;
                end
                k++;
            end
        end
        for (int j = 0; j < 7; j++) cw[1 << j] = syn[j];
        return cw;
    endfunction

    always @(negedge clk) begin : model
        int g;
        int idx;
        logic [N-1:0] exp_ready;
        if (rst) begin
            m_ptr  = 0;
            m_full = 0;
            exp_q.delete();
            dut_log.delete();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_codeword", out_codeword, 0);
            chk("rst_out_id", out_id, 0);
            chk("rst_busy", busy, |req_valid);
        end else begin
            g = -1;
            if (!m_full || out_ready) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_ready = (g >= 0) ? (N'(1) << g) : '0;
            chk("req_ready", req_ready, exp_ready);
            chk("out_valid", out_valid, m_full);
            chk("busy", busy, m_full | (|req_valid));
            for (int i = 0; i < N; i++)
                if (req_ready[i] && req_valid[i]) dut_log.push_back(i);
            if (g >= 0) begin
                exp_q.push_back('{g, ref_encode(req_data[64*g +: 64])});
                m_ptr      = (g + 1) % N;
                m_full     = 1;
                granted[g] = 1;
            end else if (out_ready) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got id %0d cw %0h expected no word", out_id, out_codeword);
            end else begin
                e = exp_q.pop_front();
                chk("out_codeword", out_codeword, e.cw);
                chk("out_id", out_id, e.id);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                granted[i]          = 0;
                req_data[64*i +: 64] = {$urandom, $urandom};
                req_valid[i]        = keep_valid[i];
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 40) begin
                    req_valid[i]         = 1'b1;
                    req_data[64*i +: 64] = {$urandom, $urandom};
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic set_keep(input bit v);
        for (int i = 0; i < N; i++) keep_valid[i] = v;
    endtask

    task automatic chk_log(input string nm, input int k, input int exp);
        chk(nm, (k < dut_log.size()) ? dut_log[k] : -1, exp);
    endtask

    initial begin
        int fair_exp [6] = '{0, 1, 2, 3, 0, 1};
        int sparse_exp [4] = '{1, 3, 1, 2};

        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) req_data[64*i +: 64] = {$urandom, $urandom};
        set_keep(0);
        step();
        step();
        rst = 1'b0;

        // Fairness: all requesters held valid, no backpressure.
        set_keep(1);
        req_valid = '1;
        out_ready = 1'b1;
        repeat (6) step();
        chk("fair_count", dut_log.size(), 6);
        for (int k = 0; k < 6; k++) chk_log($sformatf("fair_grant%0d", k), k, fair_exp[k]);

        // Backpressure while full, then release.
        out_ready = 1'b0;
        repeat (6) step();
        out_ready = 1'b1;
        repeat (2) step();

        // Reset while full, then first grant must be requester 0.
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk_log("first_after_reset", 0, 0);

        // Single words from requester 2.
        set_keep(0);
        req_valid = '0;
        step();
        req_data[128 +: 64] = 64'h1;
        req_valid[2]        = 1'b1;
        step();
        chk("single1_valid", out_valid, 1);
        chk("single1_codeword", out_codeword, 71'h7);
        chk("single1_id", out_id, 2);
        req_data[128 +: 64] = 64'h0;
        req_valid[2]        = 1'b1;
        step();
        chk("single0_valid", out_valid, 1);
        chk("single0_codeword", out_codeword, 71'h0);
        chk("single0_id", out_id, 2);
        step();

        // Sparse: requester 1 sets ptr to 2, then 1 and 3 compete, idle, then all.
        dut_log.delete();
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        step();
        step();
        step();
        req_valid = '1;
        step();
        req_valid = '0;
        chk("sparse_count", dut_log.size(), 4);
        for (int k = 0; k < 4; k++) chk_log($sformatf("sparse_grant%0d", k), k, sparse_exp[k]);

        // Random stress.
        rand_mode = 1;
        repeat (10000) step();
        rand_mode = 0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("drain_valid_left", req_valid, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
